// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned RegIdxW     = 5;
    localparam int unsigned DefaultCntW = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2,
        StError   = 2'd3
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [RegIdxW-1:0] rs1,
    input  logic [RegIdxW-1:0] rs2,
    input  logic [RegIdxW-1:0] rd,
    input  logic               memread,
    output logic               load_use
);

    // x0 is never a real producer, so a load to it cannot create a hazard.
    assign load_use = memread && (rd != '0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM (IDLE/RUN/MEM_WAIT/ERROR) with load-use, branch and memory-stall handling.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = DefaultCntW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [RegIdxW-1:0] IF_ID_rs1_i,
    input  logic [RegIdxW-1:0] IF_ID_rs2_i,
    input  logic [RegIdxW-1:0] ID_EX_rd_i,
    input  logic               ID_EX_memread_i,
    input  logic               branch_taken_i,
    input  logic               mem_busy_i,
    output logic               PC_write_o,
    output logic               IF_ID_write_o,
    output logic               IF_ID_flush_o,
    output logic               ID_EX_bubble_o,
    output logic               EX_MEM_hold_o,
    output logic [1:0]         state_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .rs1      (IF_ID_rs1_i),
        .rs2      (IF_ID_rs2_i),
        .rd       (ID_EX_rd_i),
        .memread  (ID_EX_memread_i),
        .load_use (load_use)
    );

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        PC_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        EX_MEM_hold_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                ID_EX_bubble_o = 1'b1;
                if (start_i) state_d = StRun;
            end
            StRun: begin
                if (mem_busy_i) begin
                    EX_MEM_hold_o = 1'b1;
                    state_d       = StMemWait;
                    wait_d        = CNT_W'(1);
                end else if (load_use) begin
                    ID_EX_bubble_o = 1'b1;
                end else if (branch_taken_i) begin
                    PC_write_o    = 1'b1;
                    IF_ID_write_o = 1'b1;
                    IF_ID_flush_o = 1'b1;
                end else begin
                    PC_write_o    = 1'b1;
                    IF_ID_write_o = 1'b1;
                end
            end
            StMemWait: begin
                // Freeze holds through the exit cycle; the pipeline resumes on the next one.
                EX_MEM_hold_o = 1'b1;
                if (!mem_busy_i) begin
                    state_d = StRun;
                end else if (wait_q == CNT_W'(MEM_TIMEOUT)) begin
                    state_d = StError;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StError: begin
                EX_MEM_hold_o = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Controls read as IDLE while reset is asserted, not only after the edge.
        if (rst_i) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            IF_ID_flush_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
            EX_MEM_hold_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state_o   = state_q;
    assign timeout_o = (state_q == StError);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (((state_q == StRun) || (state_q == StMemWait)) && !PC_write_o) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (IF_ID_flush_o) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed literal checks plus randomized traffic vs. a behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst, start, memread, br, busy;
    logic [4:0]    rs1, rs2, rd;
    logic          pc_w, ifid_w, flush, bubble, hold, tmo;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .IF_ID_rs1_i     (rs1),
        .IF_ID_rs2_i     (rs2),
        .ID_EX_rd_i      (rd),
        .ID_EX_memread_i (memread),
        .branch_taken_i  (br),
        .mem_busy_i      (busy),
        .PC_write_o      (pc_w),
        .IF_ID_write_o   (ifid_w),
        .IF_ID_flush_o   (flush),
        .ID_EX_bubble_o  (bubble),
        .EX_MEM_hold_o   (hold),
        .state_o         (state),
        .timeout_o       (tmo),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 waiting on memory, 3 error.
    bit            valid = 1'b0;
    int            m_mode, m_waited;
    logic [CW-1:0] m_stall, m_flush;

    always @(negedge clk) begin
        logic [4:0] e;
        bit         lu;
        lu = memread && (rd != 0) && ((rd == rs1) || (rd == rs2));
        // e = {pc_write, if_id_write, flush, bubble, hold}
        if (rst || m_mode == 0)          e = 5'b00010;
        else if (m_mode >= 2 || busy)    e = 5'b00001;
        else if (lu)                     e = 5'b00010;
        else if (br)                     e = 5'b11100;
        else                             e = 5'b11000;

        if (valid) begin
            check("m_pc_write", pc_w, e[4]);
            check("m_ifid_write", ifid_w, e[3]);
            check("m_flush", flush, e[2]);
            check("m_bubble", bubble, e[1]);
            check("m_hold", hold, e[0]);
            check("m_state", state, m_mode);
            check("m_timeout", tmo, m_mode == 3);
`ifdef PIPE_CTRL_PERF_EN
            check("m_stall_cnt", stall_cnt, m_stall);
            check("m_flush_cnt", flush_cnt, m_flush);
`else
            check("m_stall_cnt", stall_cnt, 0);
            check("m_flush_cnt", flush_cnt, 0);
`endif
        end

        if (rst) begin
            valid    = 1'b1;
            m_mode   = 0;
            m_waited = 0;
            m_stall  = '0;
            m_flush  = '0;
        end else if (valid) begin
            if ((m_mode == 1 || m_mode == 2) && !e[4]) m_stall = m_stall + 1'b1;
            if (e[2]) m_flush = m_flush + 1'b1;
            case (m_mode)
                0: if (start) m_mode = 1;
                1: if (busy) begin m_mode = 2; m_waited = 1; end
                2: begin
                    if (!busy) m_mode = 1;
                    else if (m_waited == TO) m_mode = 3;
                    else m_waited++;
                end
                default: ;
            endcase
        end
    end

    initial begin
        int holds;
        rst = 1; start = 0; memread = 0; br = 0; busy = 0; rs1 = 0; rs2 = 0; rd = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_state", state, 0);
        check("reset_pc_write", pc_w, 0);
        check("reset_bubble", bubble, 1);
        check("reset_timeout", tmo, 0);

        @(posedge clk); #1 start = 1;
        @(negedge clk); check("start_still_idle", state, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        check("start_run", state, 1);
        check("start_pc_write", pc_w, 1);

        // Load-use beats a taken branch.
        @(posedge clk); #1 memread = 1; rd = 5; rs2 = 5; br = 1;
        @(negedge clk);
        check("lu_pc_write", pc_w, 0);
        check("lu_bubble", bubble, 1);
        check("lu_flush", flush, 0);
        @(posedge clk); #1 memread = 0; br = 0;
        @(negedge clk); check("lu_release_pc", pc_w, 1);

        // Same with rd = x0: no hazard, so the branch flushes.
        @(posedge clk); #1 memread = 1; rd = 0; br = 1;
        @(negedge clk);
        check("x0_pc_write", pc_w, 1);
        check("x0_flush", flush, 1);
        check("x0_bubble", bubble, 0);
        @(posedge clk); #1 memread = 0; br = 0; rs2 = 0; rst = 1;
        @(posedge clk); #1 rst = 0; start = 1;
        @(posedge clk); #1 start = 0;

        // Three busy cycles give four freeze cycles.
        busy  = 1;
        holds = 0;
        repeat (3) begin @(negedge clk); holds += int'(hold); @(posedge clk); #1; end
        busy = 0;
        repeat (4) begin @(negedge clk); holds += int'(hold); @(posedge clk); #1; end
        check("busy3_hold_cycles", holds, 4);
        check("busy3_state", state, 1);
`ifdef PIPE_CTRL_PERF_EN
        check("busy3_stall_cnt", stall_cnt, 4);
`else
        check("busy3_stall_cnt", stall_cnt, 0);
`endif

        // Held busy times out into a sticky error.
        busy = 1;
        repeat (8) @(posedge clk);
        #1 start = 1; busy = 0;
        @(negedge clk);
        check("to_state", state, 3);
        check("to_timeout", tmo, 1);
        check("to_pc_write", pc_w, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        check("to_sticky_state", state, 3);
        check("to_sticky_timeout", tmo, 1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk); check("rst_during_bubble", bubble, 1);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("rst_exit_state", state, 0);
        check("rst_exit_timeout", tmo, 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 149) == 0);
            start   = ($urandom_range(0, 7) == 0);
            busy    = busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            memread = 1'($urandom_range(0, 1));
            rd      = 5'($urandom_range(0, 3));
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            br      = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1 rst = 0; busy = 0;
        @(negedge clk);
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64: MEM_WAIT cycles before entering ERROR.
REQ-002 Parameter CNT_W, default 32: width of the wait counter and the performance counters.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 start_i  in  1  releases the pipeline from IDLE.
REQ-006 IF_ID_rs1_i, IF_ID_rs2_i  in  5 each  source registers of the instruction in ID.
REQ-007 ID_EX_rd_i  in  5, ID_EX_memread_i  in  1  destination register and load flag of the instruction in EX.
REQ-008 branch_taken_i  in  1  branch resolved taken in ID.
REQ-009 mem_busy_i  in  1  data memory has not completed its access.
REQ-010 PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o, EX_MEM_hold_o  out  1 each  pipeline control outputs.
REQ-011 state_o  out  2  current state; timeout_o  out  1  sticky timeout error.
REQ-012 stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, MEM_WAIT, ERROR (encoded 0..3 on state_o).
REQ-014 In IDLE: PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, IF_ID_flush_o=0, EX_MEM_hold_o=0; the FSM SHALL move to RUN on the cycle after start_i=1.
REQ-015 In RUN, the outputs SHALL be combinational from the inputs, applied in priority order mem_busy_i > load-use > branch_taken_i > pass.
REQ-016 RUN with mem_busy_i=1 (freeze): PC_write_o=0, IF_ID_write_o=0, EX_MEM_hold_o=1, bubble=0, flush=0; next state MEM_WAIT; wait counter cleared to 1.
REQ-017 Load-use condition: ID_EX_memread_i=1, ID_EX_rd_i!=0, and ID_EX_rd_i equals rs1 or rs2.
REQ-018 RUN with load-use: PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1; branch_taken_i ignored that cycle; state stays RUN.
REQ-019 RUN with branch_taken_i only: PC_write_o=1, IF_ID_write_o=1, IF_ID_flush_o=1 for exactly that cycle.
REQ-020 RUN with no event: PC_write_o=1, IF_ID_write_o=1, all other control outputs 0.
REQ-021 MEM_WAIT: freeze outputs (as REQ-016) every cycle, including the exit cycle.
REQ-022 MEM_WAIT exit: when mem_busy_i=0, the next state SHALL be RUN.
REQ-023 MEM_WAIT wait counter: increments each cycle, saturating at 2^CNT_W-1.
REQ-024 MEM_WAIT timeout: counter==MEM_TIMEOUT with mem_busy_i=1 SHALL set the next state to ERROR.
REQ-025 ERROR: freeze outputs and timeout_o=1 until reset; start_i and all other inputs ignored.
REQ-026 start_i SHALL be ignored outside IDLE.

Reset
REQ-027 rst_i=1 at a clock edge SHALL force IDLE, clear the wait counter, timeout_o, and both performance counters; this applies in any state, including mid-MEM_WAIT.
REQ-028 Outputs during and after reset SHALL equal the IDLE values of REQ-014.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o counts cycles with PC_write_o=0 in RUN or MEM_WAIT; flush_cnt_o counts cycles with IF_ID_flush_o=1; both wrap modulo 2^CNT_W.
REQ-030 Macro PIPE_CTRL_PERF_EN undefined: both counter ports remain present, tied to 0, with no counter registers.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold the state enum, the register-index width (5), and the default CNT_W.
REQ-032 The load-use compare SHALL be a combinational sub-module, hazard_detect, instantiated once.

Verification
REQ-033 Reset then start_i pulse -> state_o 0 then 1 one cycle later; PC_write_o=1.
REQ-034 RUN, ID_EX_memread_i=1, ID_EX_rd_i=5, IF_ID_rs2_i=5, branch_taken_i=1 -> one cycle of PC_write_o=0, bubble=1, flush=0.
REQ-035 Same as REQ-034 with ID_EX_rd_i=0 -> no stall; flush=1.
REQ-036 mem_busy_i high 3 cycles -> 4 freeze cycles (EX_MEM_hold_o=1); stall_cnt_o=4 with PIPE_CTRL_PERF_EN defined.
REQ-037 MEM_TIMEOUT=4, mem_busy_i held -> state_o=3, timeout_o=1 persists; rst_i -> state_o=0, timeout_o=0.
